// File: rtl/matrix_stream_tx_pkg.sv
// rtl/matrix_stream_tx_pkg.sv - shared state encoding and index/offset helpers for matrix_stream_tx
package matrix_stream_tx_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Same element placement the multiplier's pack/unpack macros use.
  function automatic int elem_offset(input int i, input int j, input int cols, input int bitlength);
    return (i * cols + j) * bitlength;
  endfunction

endpackage

// File: rtl/matrix_stream_tx_if.sv
// rtl/matrix_stream_tx_if.sv - packed-matrix capture and element-stream handshake signals
interface matrix_stream_tx_if #(
  parameter int bitlength = 8,
  parameter int ROWS      = 4,
  parameter int COLS      = 3
) ();
  import matrix_stream_tx_pkg::*;

  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);

  logic                           in_valid;
  logic                           in_ready;
  logic [ROWS*COLS*bitlength-1:0] in_mat;
  logic                           out_valid;
  logic                           out_ready;
  logic [bitlength-1:0]           out_data;
  logic [RW-1:0]                  out_row;
  logic [CW-1:0]                  out_col;
  logic                           out_last_col;
  logic                           out_last;

  modport master (
    output in_valid, in_mat, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last_col, out_last
  );

  modport slave (
    input  in_valid, in_mat, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last_col, out_last
  );

endinterface

// File: rtl/matrix_idx_counter.sv
// rtl/matrix_idx_counter.sv - row/col walk counter with wrap and last flags; MATRIX_TX_COL_MAJOR_EN selects column-major order
module matrix_idx_counter
  import matrix_stream_tx_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 3,
  parameter int RW   = idx_w(ROWS),
  parameter int CW   = idx_w(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last_col,
  output logic          last
);

  logic row_end;
  logic col_end;

  assign row_end = (row == RW'(ROWS - 1));
  assign col_end = (col == CW'(COLS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
`ifdef MATRIX_TX_COL_MAJOR_EN
      row <= row_end ? '0 : row + RW'(1);
      if (row_end) col <= col_end ? '0 : col + CW'(1);
`else
      col <= col_end ? '0 : col + CW'(1);
      if (col_end) row <= row_end ? '0 : row + RW'(1);
`endif
    end
  end

`ifdef MATRIX_TX_COL_MAJOR_EN
  assign last_col = row_end;
`else
  assign last_col = col_end;
`endif
  assign last = row_end && col_end;

endmodule

// File: rtl/matrix_stream_tx.sv
// rtl/matrix_stream_tx.sv - captures a packed matrix and streams it one tagged element per beat
// Order: row-major by default, column-major when MATRIX_TX_COL_MAJOR_EN is defined.
module matrix_stream_tx
  import matrix_stream_tx_pkg::*;
#(
  parameter int bitlength = 8,
  parameter int ROWS      = 4,
  parameter int COLS      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  matrix_stream_tx_if.slave  bus
);

  localparam int RW    = idx_w(ROWS);
  localparam int CW    = idx_w(COLS);
  localparam int NBITS = ROWS * COLS * bitlength;

  state_t           state_q;
  state_t           state_d;
  logic [NBITS-1:0] mat_q;
  logic [RW-1:0]    row;
  logic [CW-1:0]    col;
  logic             last_col;
  logic             last;
  logic             capture;
  logic             beat;

  assign capture = (state_q == ST_IDLE) && bus.in_valid;
  assign beat    = (state_q == ST_SEND) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid)  state_d = ST_SEND;
      ST_SEND: if (beat && last)  state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Buffer contents are don't-care until the first capture, so no reset.
  always_ff @(posedge clk) begin
    if (capture) mat_q <= bus.in_mat;
  end

  matrix_idx_counter #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW),
    .CW   (CW)
  ) u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (capture),
    .en       (beat),
    .row      (row),
    .col      (col),
    .last_col (last_col),
    .last     (last)
  );

  always_comb begin
    bus.in_ready     = 1'b0;
    bus.out_valid    = 1'b0;
    bus.out_data     = '0;
    bus.out_row      = '0;
    bus.out_col      = '0;
    bus.out_last_col = 1'b0;
    bus.out_last     = 1'b0;
    case (state_q)
      ST_IDLE: bus.in_ready = 1'b1;
      ST_SEND: begin
        bus.out_valid    = 1'b1;
        bus.out_data     = mat_q[elem_offset(int'(row), int'(col), COLS, bitlength) +: bitlength];
        bus.out_row      = row;
        bus.out_col      = col;
        bus.out_last_col = last_col;
        bus.out_last     = last;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_matrix_stream_tx.sv
// tb/tb_matrix_stream_tx.sv - table-driven bench for matrix_stream_tx (honours MATRIX_TX_COL_MAJOR_EN)
module tb_matrix_stream_tx;

  localparam int BL = 8;
  localparam int R  = 4;
  localparam int C  = 3;
  localparam int N  = R * C;

  typedef struct {
    int         src;
    logic [7:0] data;
    int         row;
    int         col;
    logic       last_col;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_stream_tx_if #(.bitlength(BL), .ROWS(R), .COLS(C)) bus ();

  matrix_stream_tx #(.bitlength(BL), .ROWS(R), .COLS(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  beat_t exp_tab [N];

  // Element [i][j] at bits (i*3+j)*8: [60 69 78; 99 114 129; 138 159 180; 177 204 231]
  logic [N*BL-1:0] mat_a = {8'd231, 8'd204, 8'd177, 8'd180, 8'd159, 8'd138,
                            8'd129, 8'd114, 8'd99,  8'd78,  8'd69,  8'd60};
  logic [N*BL-1:0] mat_b = {8'd12, 8'd11, 8'd10, 8'd9, 8'd8, 8'd7,
                            8'd6,  8'd5,  8'd4,  8'd3, 8'd2, 8'd1};

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic build_table(input logic [N*BL-1:0] m);
    for (int k = 0; k < N; k++) begin
`ifdef MATRIX_TX_COL_MAJOR_EN
      exp_tab[k].row      = k % R;
      exp_tab[k].col      = k / R;
      exp_tab[k].last_col = (exp_tab[k].row == R - 1);
`else
      exp_tab[k].row      = k / C;
      exp_tab[k].col      = k % C;
      exp_tab[k].last_col = (exp_tab[k].col == C - 1);
`endif
      exp_tab[k].src  = exp_tab[k].row * C + exp_tab[k].col;
      exp_tab[k].data = m[exp_tab[k].src*BL +: BL];
      exp_tab[k].last = (k == N - 1);
    end
  endtask

  task automatic send_matrix(input logic [N*BL-1:0] m);
    int w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_capture", int'(bus.in_ready), 1);
    bus.in_mat   = m;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("first_beat_latency", int'(bus.out_valid), 1);
    check("in_ready_in_send", int'(bus.in_ready), 0);
  endtask

  // mode 0: always ready, 1: random ready, 2: always ready while scribbling in_mat
  task automatic run_stream(input int mode, input int nbeats);
    int    k = 0;
    int    cyc = 0;
    logic  stalled = 1'b0;
    beat_t held;
    held = exp_tab[0];
    while (k < nbeats && cyc < 400) begin
      if (mode == 2) bus.in_mat = {$urandom, $urandom, $urandom};
      bus.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      check("out_valid_in_send", int'(bus.out_valid), 1);
      if (stalled) begin
        check("stall_data", int'(bus.out_data), int'(held.data));
        check("stall_row", int'(bus.out_row), held.row);
        check("stall_col", int'(bus.out_col), held.col);
      end
      if (bus.out_ready) begin
        check($sformatf("m%0d_beat%0d_data", mode, k), int'(bus.out_data), int'(exp_tab[k].data));
        check($sformatf("m%0d_beat%0d_row", mode, k), int'(bus.out_row), exp_tab[k].row);
        check($sformatf("m%0d_beat%0d_col", mode, k), int'(bus.out_col), exp_tab[k].col);
        check($sformatf("m%0d_beat%0d_last_col", mode, k), int'(bus.out_last_col), int'(exp_tab[k].last_col));
        check($sformatf("m%0d_beat%0d_last", mode, k), int'(bus.out_last), int'(exp_tab[k].last));
        k++;
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        held.data = bus.out_data;
        held.row  = int'(bus.out_row);
        held.col  = int'(bus.out_col);
      end
      @(negedge clk);
      cyc++;
    end
    if (k < nbeats) check("stream_timeout_beats", k, nbeats);
    if (nbeats == N) begin
      check("in_ready_after_last", int'(bus.in_ready), 1);
      check("out_valid_after_last", int'(bus.out_valid), 0);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mat    = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_row", int'(bus.out_row), 0);
    check("rst_out_col", int'(bus.out_col), 0);
    check("rst_out_last_col", int'(bus.out_last_col), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    rst_n = 1'b1;
    @(negedge clk);

    build_table(mat_a);
    send_matrix(mat_a);
    run_stream(0, N);
    send_matrix(mat_a);
    run_stream(1, N);
    send_matrix(mat_a);
    run_stream(2, N);

    // Abort after five beats, then a fresh matrix must start at [0][0].
    send_matrix(mat_a);
    run_stream(0, 5);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    check("midrst_out_data", int'(bus.out_data), 0);
    check("midrst_out_row", int'(bus.out_row), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    build_table(mat_b);
    send_matrix(mat_b);
    run_stream(0, N);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_stream_tx.md
Name: matrix_stream_tx

Overview:
- Transmit side of the packed-matrix interface used by the matrix datapath.
- Accepts one whole matrix on a flat packed bus (the same layout the matrix multiplier drives on its result port) through a valid/ready handshake.
- Holds the matrix in an internal buffer, then streams it out one element per accepted beat with row/column tags and last flags.
- Sits between the combinational multiplier output and serial consumers such as a memory writer or host readback.

Parameters:
- bitlength, 8, width of one matrix element in bits
- ROWS, 4, number of matrix rows (≥1)
- COLS, 3, number of matrix columns (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_mat holds a complete matrix
- in_ready  out  1  block can capture a matrix this cycle
- in_mat  in  ROWS*COLS*bitlength  packed matrix; element [i][j] occupies bits (i*COLS+j)*bitlength +: bitlength
- out_valid  out  1  out_data/tags valid
- out_ready  in  1  consumer accepts current beat
- out_data  out  bitlength  current element
- out_row  out  max(1,$clog2(ROWS))  row index of out_data
- out_col  out  max(1,$clog2(COLS))  column index of out_data
- out_last_col  out  1  element is the last of its row (last of its column in column-major mode)
- out_last  out  1  element is the final element of the matrix

Behaviour:
- Interface: one clock domain; rst_n asynchronous active-low, deasserted synchronously to clk by the reset tree.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_row=0, out_col=0, out_last_col=0, out_last=0; matrix buffer contents don't-care.
- FSM states: IDLE, SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid=1, capture in_mat into the buffer, reset row=0/col=0, and go to SEND.
- SEND:
  - in_ready=0, out_valid=1.
  - out_data = buffer[row][col]; tags come from registered counters.
  - Outputs are held stable while out_ready=0; no element is skipped or duplicated.
- Beat transfer: a beat transfers when out_valid and out_ready are both 1 at a rising clk edge.
- Row-major order:
  - On transfer, col increments.
  - When col==COLS-1, col wraps to 0 and row increments.
  - When row==ROWS-1 and col==COLS-1 (out_last=1), the next state is IDLE.
- Latency: first element is valid in the cycle after the capture edge. A matrix takes ROWS*COLS transferring beats.
- Back-to-back matrices: in_ready rises in the cycle after the final transfer; that is one bubble cycle between matrices.
- Flags: out_last_col = (col==COLS-1); out_last = (row==ROWS-1 && col==COLS-1). Both are combinational from the counters and gated by out_valid.
- Degenerate sizes: ROWS=COLS=1 gives a single beat with out_last=out_last_col=1.
- in_mat is ignored outside IDLE. Changes to in_mat after capture do not affect the stream.
- Reset mid-stream aborts immediately: outputs return to reset values and the partially sent matrix is discarded.
- No arithmetic on data; elements are passed through unmodified.

Optional Feature:
- Macro: MATRIX_TX_COL_MAJOR_EN.
- Defined: elements are emitted column-major. row increments first; on row==ROWS-1 it wraps and col increments. out_last_col marks row==ROWS-1. out_last is unchanged (final element [ROWS-1][COLS-1]).
- Undefined: row-major as above.
- Port list is identical in both builds.

Decomposition:
- Shared package/config include holds:
  - state encoding constants (ST_IDLE, ST_SEND)
  - index-width helper (max(1,$clog2(n)))
  - packed-element offset helper, shared with the multiplier's pack/unpack macros
- One natural sub-module: matrix_idx_counter, a row/col counter with enable, wrap, order select and last flags. The top holds the FSM, buffer and mux.

Test Plan:
- Reset: hold rst_n=0 → in_ready=1, out_valid=0, all tag outputs 0.
- Basic stream, out_ready=1: capture the 4x3 matrix [60 69 78; 99 114 129; 138 159 180; 177 204 231] → 12 beats in order 60,69,78,99,…,231. out_last_col is set on 78, 129, 180 and 231; out_last is set only on 231 (row=3, col=2). in_ready returns to 1 the cycle after.
- Backpressure: same matrix, out_ready toggling randomly → every element is delivered exactly once, in order, and out_data is stable while stalled.
- Input ignored: change in_mat while in SEND → streamed values still match the matrix captured at the capture edge.
- Reset mid-operation: assert rst_n=0 after beat 5 → out_valid drops asynchronously. After reset, a new matrix streams from element [0][0].
- MATRIX_TX_COL_MAJOR_EN build: same matrix → order is 60,99,138,177,69,…,231. out_last_col is set on 177, 204 and 231; out_last is set on 231.
